hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter: REGW, 4, register-address width (16-entry register file; address 15 is the PC).
REQ-002 Parameter: CNTW, 16, width of the stall-event counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 RA1D  input  REGW  source register 1 of the decode-stage instruction.
REQ-006 RA2D  input  REGW  source register 2 of the decode-stage instruction.
REQ-007 WA3D  input  REGW  destination register of the decode-stage instruction.
REQ-008 RegWriteD  input  1  decode instruction writes the register file.
REQ-009 MemtoRegD  input  1  decode instruction is a load.
REQ-010 BranchTakenE  input  1  branch resolved taken in execute this cycle.
REQ-011 ForwardAE  output  2  select for the SrcA 3-way mux: 00 register file, 01 writeback result, 10 memory-stage ALU result.
REQ-012 ForwardBE  output  2  same encoding for SrcB.
REQ-013 StallF  output  1  hold PC.
REQ-014 StallD  output  1  hold IF/ID register.
REQ-015 FlushD  output  1  clear IF/ID register.
REQ-016 FlushE  output  1  clear ID/EX register.
REQ-017 StallCount  output  CNTW  saturating count of load-use stall cycles.

Function
REQ-018 Internal shadow pipeline: E slot {RA1E, RA2E, WA3E, RegWriteE, MemtoRegE}; M slot {WA3M, RegWriteM}; W slot {WA3W, RegWriteW}.
REQ-019 Each edge: D->E, E->M, M->W; when FlushE=1 the E slot loads a bubble (all fields 0); M and W always advance.
REQ-020 lwstall = MemtoRegE & RegWriteE & (WA3E==RA1D | WA3E==RA2D) & ~BranchTakenE.
REQ-021 StallF = StallD = lwstall; FlushE = lwstall | BranchTakenE; FlushD = BranchTakenE; all combinational from current state/inputs, same cycle.
REQ-022 ForwardAE = 10 if RegWriteM & WA3M==RA1E; else 01 if RegWriteW & WA3W==RA1E; else 00 -- M has priority over W when both match.
REQ-023 ForwardBE: identical rule on RA2E.
REQ-024 No forwarding when the source address equals 15 (PC); select forced 00.
REQ-025 StallCount increments by 1 on each edge where lwstall=1; saturates at all-ones, no wrap.
REQ-026 Forward selects never take value 11.

Reset
REQ-027 reset=0 asynchronously clears all shadow-pipeline fields and StallCount to 0.
REQ-028 During and immediately after reset: ForwardAE=ForwardBE=00, StallF=StallD=FlushD=FlushE=0, StallCount=0.
REQ-029 Reset asserted mid-stall aborts the stall; the first post-reset cycle shows no stall/forward unless caused by new D inputs.

Structure
REQ-030 Shared package holds forward-select constants (FWD_RF=00, FWD_WB=01, FWD_MEM=10), REGW default and PC address 15.
REQ-031 One sub-module, hazard_pipe_reg: flush-able, async active-low-reset register used for E, M, W slots.
REQ-032 Forwarding and stall logic stay combinational in the top module; no latches.

Verification
REQ-033 Back-to-back ALU ops: D writes R3, next D reads RA1=R3 -> next cycle ForwardAE=10; one cycle later (if still read) 01.
REQ-034 Load R2 then dependent RA2D=R2 -> StallF=StallD=FlushE=1 for exactly one cycle, then ForwardBE=01, StallCount=1.
REQ-035 Load-use coinciding with BranchTakenE=1 -> FlushD=FlushE=1, StallF=StallD=0, StallCount unchanged.
REQ-036 M and W both write R5, E reads R5 on both ports -> ForwardAE=ForwardBE=10.
REQ-037 Writes/reads targeting R15 -> selects stay 00; StallCount preloaded near max via 65535+ stalls -> holds 0xFFFF.
REQ-038 Async reset pulsed mid-stall between edges -> all outputs 0 immediately, shadow pipeline empty afterwards.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared constants for the pipeline hazard unit: forward-mux encodings,
// default register-address width and the PC register index.
package hazard_unit_pkg;

  localparam int REGW_DEF = 4;
  localparam int PC_ADDR  = 15;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_WB  = 2'b01;
  localparam fwd_sel_t FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_unit_pipe_reg.sv
// Shadow pipeline slot register: synchronous flush loads a bubble (all zeros),
// asynchronous active-low reset empties the slot.
module hazard_pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Advance the slot every edge; a flush inserts a bubble instead of i_d.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_q <= '0;
    else if (i_flush) r_q <= '0;
    else              r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/hazard_unit.sv
// Hazard unit for a 5-stage pipeline: tracks E/M/W register usage in a shadow
// pipeline, generates forwarding selects, load-use stalls and branch flushes,
// and counts load-use stall cycles with saturation.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int REGW = REGW_DEF,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [REGW-1:0] RA1D,
  input  logic [REGW-1:0] RA2D,
  input  logic [REGW-1:0] WA3D,
  input  logic            RegWriteD,
  input  logic            MemtoRegD,
  input  logic            BranchTakenE,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
  output logic            StallF,
  output logic            StallD,
  output logic            FlushD,
  output logic            FlushE,
  output logic [CNTW-1:0] StallCount
);

  localparam int EW = 3 * REGW + 2;
  localparam int MW = REGW + 1;
  localparam logic [REGW-1:0] PC_REG = REGW'(PC_ADDR);

  logic [EW-1:0]   w_e_q;
  logic [MW-1:0]   w_m_q;
  logic [MW-1:0]   w_w_q;
  logic [REGW-1:0] w_ra1e, w_ra2e, w_wa3e, w_wa3m, w_wa3w;
  logic            w_rwe, w_mre, w_rwm, w_rww;
  logic            w_bt;
  logic            w_lwstall;
  logic            w_flush_e;
  logic [CNTW-1:0] r_stall_cnt;

  hazard_pipe_reg #(.W(EW)) u_e_slot (
    .clk     (clk),
    .rst_n   (reset),
    .i_flush (w_flush_e),
    .i_d     ({RA1D, RA2D, WA3D, RegWriteD, MemtoRegD}),
    .o_q     (w_e_q)
  );

  hazard_pipe_reg #(.W(MW)) u_m_slot (
    .clk     (clk),
    .rst_n   (reset),
    .i_flush (1'b0),
    .i_d     ({w_wa3e, w_rwe}),
    .o_q     (w_m_q)
  );

  hazard_pipe_reg #(.W(MW)) u_w_slot (
    .clk     (clk),
    .rst_n   (reset),
    .i_flush (1'b0),
    .i_d     ({w_wa3m, w_rwm}),
    .o_q     (w_w_q)
  );

  assign {w_ra1e, w_ra2e, w_wa3e, w_rwe, w_mre} = w_e_q;
  assign {w_wa3m, w_rwm} = w_m_q;
  assign {w_wa3w, w_rww} = w_w_q;

  // Branch is ignored while reset is held so no flush shows during reset.
  assign w_bt = BranchTakenE & reset;

  assign w_lwstall = w_mre & w_rwe & ((w_wa3e == RA1D) | (w_wa3e == RA2D)) & ~w_bt;
  assign w_flush_e = w_lwstall | w_bt;

  assign StallF = w_lwstall;
  assign StallD = w_lwstall;
  assign FlushD = w_bt;
  assign FlushE = w_flush_e;

  // Memory stage wins over writeback; the PC is never forwarded.
  function automatic fwd_sel_t fwd_select(input logic [REGW-1:0] src,
                                          input logic [REGW-1:0] wa_m, input logic rw_m,
                                          input logic [REGW-1:0] wa_w, input logic rw_w);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (src != PC_REG) begin
      if (rw_m && (wa_m == src))      sel = FWD_MEM;
      else if (rw_w && (wa_w == src)) sel = FWD_WB;
    end
    return sel;
  endfunction

  assign ForwardAE = fwd_select(w_ra1e, w_wa3m, w_rwm, w_wa3w, w_rww);
  assign ForwardBE = fwd_select(w_ra2e, w_wa3m, w_rwm, w_wa3w, w_rww);

  // Count load-use stall cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                 r_stall_cnt <= '0;
    else if (w_lwstall && (r_stall_cnt != '1))  r_stall_cnt <= r_stall_cnt + CNTW'(1);
  end

  assign StallCount = r_stall_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: forwarding, load-use stall, branch flush,
// PC exclusion, async reset mid-stall and counter saturation.
module tb_hazard_unit;

  logic        clk;
  logic        reset;
  logic [3:0]  RA1D, RA2D, WA3D;
  logic        RegWriteD, MemtoRegD, BranchTakenE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, FlushD, FlushE;
  logic [15:0] StallCount;

  logic [1:0]  s_fa, s_fb;
  logic        s_sf, s_sd, s_fd, s_fe;
  logic [3:0]  s_cnt;

  int errors = 0;
  int checks = 0;

  hazard_unit dut (
    .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .BranchTakenE(BranchTakenE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE), .StallCount(StallCount)
  );

  // Narrow-counter copy sharing all inputs, used to reach saturation quickly.
  hazard_unit #(.CNTW(4)) dut_sat (
    .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .BranchTakenE(BranchTakenE),
    .ForwardAE(s_fa), .ForwardBE(s_fb), .StallF(s_sf), .StallD(s_sd),
    .FlushD(s_fd), .FlushE(s_fe), .StallCount(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_d(input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa3,
                       input logic rw, input logic mr);
    RA1D = ra1; RA2D = ra2; WA3D = wa3; RegWriteD = rw; MemtoRegD = mr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nops(input int n);
    set_d(4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b0;
    BranchTakenE = 1'b1;
    set_d(4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    tick();
    tick();
    check_val("rst_fwda", ForwardAE, 2'b00);
    check_val("rst_fwdb", ForwardBE, 2'b00);
    check_val("rst_stall", {StallF, StallD}, 2'b00);
    check_val("rst_flush", {FlushD, FlushE}, 2'b00);
    check_val("rst_cnt", StallCount, 16'd0);
    BranchTakenE = 1'b0;
    reset = 1'b1;
    #1;

    // Back-to-back ALU dependency on R3
    set_d(4'd1, 4'd4, 4'd3, 1'b1, 1'b0);
    tick();
    set_d(4'd3, 4'd6, 4'd7, 1'b1, 1'b0);
    check_val("alu_fwda_none", ForwardAE, 2'b00);
    tick();
    check_val("alu_fwda_mem", ForwardAE, 2'b10);
    check_val("alu_fwdb_mem", ForwardBE, 2'b00);
    tick();
    check_val("alu_fwda_wb", ForwardAE, 2'b01);
    check_val("alu_fwdb_wb", ForwardBE, 2'b00);
    nops(3);

    // Load R2 followed by a dependent read on port B
    set_d(4'd1, 4'd0, 4'd2, 1'b1, 1'b1);
    tick();
    set_d(4'd5, 4'd2, 4'd8, 1'b1, 1'b0);
    check_val("lw_stall", {StallF, StallD, FlushE, FlushD}, 4'b1110);
    tick();
    check_val("lw_stall_once", {StallF, StallD, FlushE}, 3'b000);
    check_val("lw_cnt1", StallCount, 16'd1);
    tick();
    check_val("lw_fwdb_wb", ForwardBE, 2'b01);
    check_val("lw_fwda_none", ForwardAE, 2'b00);
    check_val("lw_cnt_hold", StallCount, 16'd1);
    nops(3);

    // Load-use coinciding with a taken branch
    set_d(4'd1, 4'd0, 4'd2, 1'b1, 1'b1);
    tick();
    BranchTakenE = 1'b1;
    set_d(4'd0, 4'd2, 4'd8, 1'b1, 1'b0);
    check_val("br_flush", {FlushD, FlushE}, 2'b11);
    check_val("br_nostall", {StallF, StallD}, 2'b00);
    tick();
    BranchTakenE = 1'b0;
    set_d(4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    check_val("br_cnt", StallCount, 16'd1);
    check_val("br_after", {StallF, FlushE, FlushD}, 3'b000);
    nops(3);

    // M and W both writing R5; E reads R5 on both ports
    set_d(4'd0, 4'd0, 4'd5, 1'b1, 1'b0);
    tick();
    set_d(4'd0, 4'd0, 4'd5, 1'b1, 1'b0);
    tick();
    set_d(4'd5, 4'd5, 4'd0, 1'b0, 1'b0);
    tick();
    check_val("prio_fwda", ForwardAE, 2'b10);
    check_val("prio_fwdb", ForwardBE, 2'b10);
    nops(3);

    // R15 (PC) is never forwarded
    set_d(4'd0, 4'd0, 4'd15, 1'b1, 1'b0);
    tick();
    set_d(4'd15, 4'd15, 4'd0, 1'b0, 1'b0);
    tick();
    check_val("pc_fwd_mem", {ForwardAE, ForwardBE}, 4'b0000);
    set_d(4'd15, 4'd15, 4'd0, 1'b0, 1'b0);
    tick();
    check_val("pc_fwd_wb", {ForwardAE, ForwardBE}, 4'b0000);
    nops(3);

    // Async reset pulsed in the middle of a stall cycle
    set_d(4'd1, 4'd0, 4'd2, 1'b1, 1'b1);
    tick();
    set_d(4'd2, 4'd0, 4'd0, 1'b0, 1'b0);
    check_val("mid_stall_pre", StallF, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_val("mid_rst_out", {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE}, 8'h00);
    check_val("mid_rst_cnt", StallCount, 16'd0);
    #1;
    reset = 1'b1;
    tick();
    check_val("post_rst_stall", {StallF, FlushE}, 2'b00);
    check_val("post_rst_fwd", {ForwardAE, ForwardBE}, 4'b0000);
    check_val("post_rst_cnt", StallCount, 16'd0);

    // Repeated self-dependent loads: one stall every two cycles
    set_d(4'd2, 4'd0, 4'd2, 1'b1, 1'b1);
    for (int i = 0; i < 30; i++) tick();
    check_val("sat_cnt15_main", StallCount, 16'd15);
    check_val("sat_cnt15_small", s_cnt, 4'd15);
    for (int i = 0; i < 10; i++) tick();
    check_val("sat_cnt20_main", StallCount, 16'd20);
    check_val("sat_hold_small", s_cnt, 4'd15);
    nops(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
